// File: rtl/inst_queue_mp_pkg.sv
// inst_queue_mp_pkg
// Shared frontend types for the instruction queue slice.
//   fetch_entry_t     : one fetched instruction {refill, invalid, addr, data}
//   FETCH_ENTRY_ZERO  : all-zero entry, driven on empty read lanes
//   iq_state_e        : queue control states
package inst_queue_mp_pkg;

  typedef struct packed {
    logic        refill;
    logic        invalid;
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;

  localparam fetch_entry_t FETCH_ENTRY_ZERO = '0;

  // WAIT_DS: the queue is empty and the delay slot of a flushed branch
  // has not been fetched yet.
  typedef enum logic {
    NORMAL,
    WAIT_DS
  } iq_state_e;

endpackage

// File: rtl/iq_lane_select.sv
// iq_lane_select
// Combinational pick of element i_idx from the sequence formed by the first
// i_storedCnt entries of i_stored followed by the first i_incomingCnt entries
// of i_incoming. Drives FETCH_ENTRY_ZERO with o_valid=0 when the index is
// past the end of that sequence.
//   i_stored      : NS entries read from the queue head onwards
//   i_storedCnt   : number of stored entries that are real
//   i_incoming    : NI write lanes of this cycle
//   i_incomingCnt : number of accepted incoming lanes (contiguous from 0)
//   i_idx         : position to select
//   o_valid/o_entry : selected entry
module iq_lane_select
  import inst_queue_mp_pkg::*;
#(
  parameter int NS = 3,
  parameter int NI = 2,
  parameter int CW = 5,
  parameter int IW = 2
) (
  input  fetch_entry_t     i_stored      [NS],
  input  logic [CW-1:0]    i_storedCnt,
  input  fetch_entry_t     i_incoming    [NI],
  input  logic [CW-1:0]    i_incomingCnt,
  input  logic [IW-1:0]    i_idx,
  output logic             o_valid,
  output fetch_entry_t     o_entry
);

  localparam int XW = CW + 1;

  logic [XW-1:0] w_idx;
  assign w_idx = XW'(i_idx);

  // Stored and incoming candidates are mutually exclusive: an incoming lane
  // only matches at positions at or beyond the stored count.
  always_comb begin
    o_valid = 1'b0;
    o_entry = FETCH_ENTRY_ZERO;
    for (int s = 0; s < NS; s++) begin
      if ((w_idx == XW'(s)) && (XW'(s) < XW'(i_storedCnt))) begin
        o_valid = 1'b1;
        o_entry = i_stored[s];
      end
    end
    for (int k = 0; k < NI; k++) begin
      if ((w_idx == (XW'(i_storedCnt) + XW'(k))) && (XW'(k) < XW'(i_incomingCnt))) begin
        o_valid = 1'b1;
        o_entry = i_incoming[k];
      end
    end
  end

endmodule

// File: rtl/inst_queue_mp.sv
// inst_queue_mp
// Multi-port instruction queue between fetch and decode/issue.
//   clk, rst          : clock, synchronous active-high reset
//   i_wr_valid/entry  : up to NW fetched entries per cycle (lanes contiguous)
//   o_wr_ready        : at least NW free slots (always 1 while waiting for a delay slot)
//   o_rd_valid/entry  : up to NR head entries, lane 0 oldest, zeros when invalid
//   i_rd_num          : entries consumed this cycle
//   i_rd_branch       : issued lane i is a branch/jump
//   o_head_in_ds      : rd_entry[0] is a delay-slot instruction
//   i_flush/keep_ds/ds_off : redirect, optionally retaining the delay slot at ds_off
//   o_count           : occupancy 0..DEPTH
//   o_issued_cnt      : total entries consumed
module inst_queue_mp
  import inst_queue_mp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int NW    = 2,
  parameter int NR    = 2,
  localparam int PTRW = $clog2(DEPTH),
  localparam int CNTW = $clog2(DEPTH) + 1,
  localparam int NUMW = $clog2(NR + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NW-1:0]     i_wr_valid,
  input  fetch_entry_t      i_wr_entry   [NW],
  output logic              o_wr_ready,
  output logic [NR-1:0]     o_rd_valid,
  output fetch_entry_t      o_rd_entry   [NR],
  input  logic [NUMW-1:0]   i_rd_num,
  input  logic [NR-1:0]     i_rd_branch,
  output logic              o_head_in_ds,
  input  logic              i_flush,
  input  logic              i_keep_ds,
  input  logic [NUMW-1:0]   i_ds_off,
  output logic [CNTW-1:0]   o_count,
  output logic [63:0]       o_issued_cnt
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTRW-1:0]  r_rdPtr, r_wrPtr, w_rdPtrNext, w_wrPtrNext;
  logic [CNTW-1:0]  r_count, w_countNext;
  iq_state_e        r_state, w_stateNext;
  logic [NUMW-1:0]  r_skip, w_skipNext;
  logic             r_headInDs, w_headInDsNext;
  logic [63:0]      r_issuedCnt;

  logic [CNTW-1:0]  w_numAcc;
  fetch_entry_t     w_window [NR+1];
  fetch_entry_t     w_noIncoming [1];
  logic [NUMW-1:0]  w_keepIdx;
  logic             w_keepValid;
  fetch_entry_t     w_keepEntry;
  logic             w_keepWrite;
  logic             w_lastBranch;

  // Ready is judged on the pre-read occupancy, so a same-cycle read never
  // makes room for a write.
  assign o_wr_ready = (r_state == WAIT_DS) || ((CNTW'(DEPTH) - r_count) >= CNTW'(NW));

  always_comb begin
    w_numAcc = '0;
    for (int k = 0; k < NW; k++) begin
      if (o_wr_ready && i_wr_valid[k]) w_numAcc = w_numAcc + CNTW'(1);
    end
  end

  // NR+1 entries from the head: enough for reads and for S[ds_off] with ds_off <= NR.
  for (genvar j = 0; j <= NR; j++) begin : g_window
    assign w_window[j] = r_mem[r_rdPtr + PTRW'(j)];
  end

  assign w_noIncoming[0] = FETCH_ENTRY_ZERO;

  for (genvar i = 0; i < NR; i++) begin : g_rdLane
    iq_lane_select #(.NS(NR + 1), .NI(1), .CW(CNTW), .IW(NUMW)) u_rdSel (
      .i_stored      (w_window),
      .i_storedCnt   (r_count),
      .i_incoming    (w_noIncoming),
      .i_incomingCnt ('0),
      .i_idx         (NUMW'(i)),
      .o_valid       (o_rd_valid[i]),
      .o_entry       (o_rd_entry[i])
    );
  end

  // While waiting for the delay slot the queue is empty (count 0), so the same
  // selector picks incoming lane r_skip without a separate path.
  assign w_keepIdx = i_flush ? i_ds_off : r_skip;

  iq_lane_select #(.NS(NR + 1), .NI(NW), .CW(CNTW), .IW(NUMW)) u_keepSel (
    .i_stored      (w_window),
    .i_storedCnt   (r_count),
    .i_incoming    (i_wr_entry),
    .i_incomingCnt (w_numAcc),
    .i_idx         (w_keepIdx),
    .o_valid       (w_keepValid),
    .o_entry       (w_keepEntry)
  );

  always_comb begin
    w_lastBranch = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (i_rd_num == NUMW'(i + 1)) w_lastBranch = i_rd_branch[i];
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_skipNext     = r_skip;
    w_countNext    = r_count;
    w_rdPtrNext    = r_rdPtr;
    w_wrPtrNext    = r_wrPtr;
    w_headInDsNext = r_headInDs;
    w_keepWrite    = 1'b0;
    if (i_flush) begin
      w_stateNext    = NORMAL;
      w_skipNext     = '0;
      w_countNext    = '0;
      w_headInDsNext = 1'b0;
      if (!i_keep_ds) begin
        w_rdPtrNext = r_wrPtr;
      end else if (w_keepValid) begin
        w_keepWrite    = 1'b1;
        w_wrPtrNext    = r_rdPtr + PTRW'(1);
        w_countNext    = CNTW'(1);
        w_headInDsNext = 1'b1;
      end else begin
        w_wrPtrNext = r_rdPtr;
        w_stateNext = WAIT_DS;
        w_skipNext  = NUMW'(CNTW'(i_ds_off) - (r_count + w_numAcc));
      end
    end else if (r_state == WAIT_DS) begin
      if (w_keepValid) begin
        w_keepWrite    = 1'b1;
        w_wrPtrNext    = r_rdPtr + PTRW'(1);
        w_countNext    = CNTW'(1);
        w_headInDsNext = 1'b1;
        w_stateNext    = NORMAL;
        w_skipNext     = '0;
      end else begin
        w_skipNext = r_skip - NUMW'(w_numAcc);
      end
    end else begin
      w_rdPtrNext = r_rdPtr + PTRW'(i_rd_num);
      w_wrPtrNext = r_wrPtr + PTRW'(w_numAcc);
      w_countNext = r_count + w_numAcc - CNTW'(i_rd_num);
      if (i_rd_num != '0) w_headInDsNext = w_lastBranch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= NORMAL;
      r_skip      <= '0;
      r_count     <= '0;
      r_rdPtr     <= '0;
      r_wrPtr     <= '0;
      r_headInDs  <= 1'b0;
      r_issuedCnt <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_skip      <= w_skipNext;
      r_count     <= w_countNext;
      r_rdPtr     <= w_rdPtrNext;
      r_wrPtr     <= w_wrPtrNext;
      r_headInDs  <= w_headInDsNext;
      r_issuedCnt <= r_issuedCnt + 64'(i_rd_num);
    end
  end

  // Storage is not reset. A retained delay slot overwrites the head slot.
  always_ff @(posedge clk) begin
    if (w_keepWrite) begin
      r_mem[r_rdPtr] <= w_keepEntry;
    end else if (!i_flush && (r_state == NORMAL)) begin
      for (int k = 0; k < NW; k++) begin
        if (o_wr_ready && i_wr_valid[k]) r_mem[r_wrPtr + PTRW'(k)] <= i_wr_entry[k];
      end
    end
  end

  assign o_head_in_ds = r_headInDs;
  assign o_count      = r_count;
  assign o_issued_cnt = r_issuedCnt;

  a_rdNumLegal: assert property (@(posedge clk) disable iff (rst)
    (i_rd_num <= NUMW'(NR)) && (CNTW'(i_rd_num) <= r_count));

endmodule

// File: tb/tb_inst_queue_mp.sv
// tb_inst_queue_mp
// Directed and randomized stimulus for inst_queue_mp, checked every cycle
// against a queue-based reference model of the instruction queue.
module tb_inst_queue_mp;
  import inst_queue_mp_pkg::*;

  localparam int DEPTH = 16;
  localparam int NW    = 2;
  localparam int NR    = 2;

  logic            clk;
  logic            rst;
  logic [NW-1:0]   wrValid;
  fetch_entry_t    wrEntry [NW];
  logic            wrReady;
  logic [NR-1:0]   rdValid;
  fetch_entry_t    rdEntry [NR];
  logic [1:0]      rdNum;
  logic [NR-1:0]   rdBranch;
  logic            headInDs;
  logic            flush;
  logic            keepDs;
  logic [1:0]      dsOff;
  logic [4:0]      count;
  logic [63:0]     issuedCnt;

  inst_queue_mp #(.DEPTH(DEPTH), .NW(NW), .NR(NR)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_wr_valid   (wrValid),
    .i_wr_entry   (wrEntry),
    .o_wr_ready   (wrReady),
    .o_rd_valid   (rdValid),
    .o_rd_entry   (rdEntry),
    .i_rd_num     (rdNum),
    .i_rd_branch  (rdBranch),
    .o_head_in_ds (headInDs),
    .i_flush      (flush),
    .i_keep_ds    (keepDs),
    .i_ds_off     (dsOff),
    .o_count      (count),
    .o_issued_cnt (issuedCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the queue contents in program order plus the
  // delay-slot bookkeeping.
  fetch_entry_t    mq[$];
  fetch_entry_t    mS[$];
  fetch_entry_t    mAcc[$];
  bit              mWait;
  int              mSkip;
  bit              mHds;
  longint unsigned mIssued;

  fetch_entry_t    lastLanes [NW];
  fetch_entry_t    expKeep;
  logic [31:0]     nextAddr;
  int              checks;
  int              errors;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic driveLanes(input int nWr);
    wrValid = '0;
    for (int k = 0; k < NW; k++) begin
      lastLanes[k].refill  = 1'($urandom_range(0, 1));
      lastLanes[k].invalid = 1'($urandom_range(0, 1));
      lastLanes[k].addr    = nextAddr;
      lastLanes[k].data    = $urandom;
      if (k < nWr) begin
        wrValid[k] = 1'b1;
        nextAddr   = nextAddr + 32'd4;
      end
      wrEntry[k] = lastLanes[k];
    end
  endtask

  task automatic modelStep(input int nWr, input int rdN, input logic [NR-1:0] br,
                           input bit fl, input bit kd, input int off);
    bit ready;
    ready = mWait || ((DEPTH - mq.size()) >= NW);
    mAcc.delete();
    if (ready) for (int k = 0; k < nWr; k++) mAcc.push_back(lastLanes[k]);
    mIssued += longint'(rdN);
    if (fl) begin
      mS = mq;
      foreach (mAcc[k]) mS.push_back(mAcc[k]);
      mq.delete();
      mWait = 0;
      mHds  = 0;
      if (kd) begin
        if (mS.size() > off) begin
          mq.push_back(mS[off]);
          mHds = 1;
        end else begin
          mWait = 1;
          mSkip = off - mS.size();
        end
      end
    end else if (mWait) begin
      foreach (mAcc[k]) begin
        if (mWait) begin
          if (mSkip > 0) mSkip--;
          else begin
            mq.push_back(mAcc[k]);
            mWait = 0;
            mHds  = 1;
          end
        end
      end
    end else begin
      if (rdN > 0) mHds = br[rdN-1];
      repeat (rdN) void'(mq.pop_front());
      foreach (mAcc[k]) mq.push_back(mAcc[k]);
    end
  endtask

  task automatic applyStimulus(input int nWr, input int rdN, input logic [NR-1:0] br,
                               input bit fl, input bit kd, input int off);
    driveLanes(nWr);
    rdNum    = 2'(rdN);
    rdBranch = br;
    flush    = fl;
    keepDs   = kd;
    dsOff    = 2'(off);
    @(posedge clk);
    modelStep(nWr, rdN, br, fl, kd, off);
    #1;
  endtask

  task automatic applyReset(input int nWr);
    rst = 1'b1;
    driveLanes(nWr);
    rdNum    = '0;
    rdBranch = '0;
    flush    = 1'b0;
    keepDs   = 1'b0;
    dsOff    = '0;
    @(posedge clk);
    mq.delete();
    mWait   = 0;
    mSkip   = 0;
    mHds    = 0;
    mIssued = 0;
    #1;
    rst     = 1'b0;
    wrValid = '0;
  endtask

  task automatic checkOutput();
    bit expReady;
    expReady = mWait || ((DEPTH - mq.size()) >= NW);
    check("count", 128'(count), 128'(mq.size()));
    check("wr_ready", 128'(wrReady), 128'(expReady));
    for (int i = 0; i < NR; i++) begin
      check($sformatf("rd_valid[%0d]", i), 128'(rdValid[i]), 128'(i < mq.size()));
      check($sformatf("rd_entry[%0d]", i), 128'(rdEntry[i]),
            (i < mq.size()) ? 128'(mq[i]) : 128'(FETCH_ENTRY_ZERO));
    end
    if (!mWait) check("head_in_ds", 128'(headInDs), 128'(mHds));
    check("issued_cnt", 128'(issuedCnt), 128'(mIssued));
  endtask

  initial begin
    int maxR;
    checks   = 0;
    errors   = 0;
    nextAddr = 32'h1000;
    rst      = 1'b1;
    wrValid  = '0;
    rdNum    = '0;
    rdBranch = '0;
    flush    = 1'b0;
    keepDs   = 1'b0;
    dsOff    = '0;
    for (int k = 0; k < NW; k++) wrEntry[k] = FETCH_ENTRY_ZERO;

    // Reset state
    applyReset(0);
    checkOutput();
    check("reset_wr_ready", 128'(wrReady), 128'(1));

    // Fill to capacity, then an ignored ninth beat
    for (int b = 0; b < 8; b++) begin
      applyStimulus(2, 0, '0, 0, 0, 0);
      checkOutput();
    end
    check("fill_count", 128'(count), 128'(16));
    check("fill_wr_ready", 128'(wrReady), 128'(0));
    applyStimulus(2, 0, '0, 0, 0, 0);
    checkOutput();
    check("ninth_count", 128'(count), 128'(16));

    // Drain two per cycle, in order from 0x1000
    for (int b = 0; b < 8; b++) begin
      check("drain_addr0", 128'(rdEntry[0].addr), 128'(32'h1000 + 32'(8 * b)));
      check("drain_addr1", 128'(rdEntry[1].addr), 128'(32'h1004 + 32'(8 * b)));
      applyStimulus(0, 2, '0, 0, 0, 0);
      checkOutput();
    end

    // Move both pointers to slot 15, then straddle the wrap
    for (int b = 0; b < 7; b++) applyStimulus(2, 0, '0, 0, 0, 0);
    applyStimulus(1, 0, '0, 0, 0, 0);
    checkOutput();
    for (int b = 0; b < 7; b++) applyStimulus(0, 2, '0, 0, 0, 0);
    applyStimulus(0, 1, '0, 0, 0, 0);
    checkOutput();
    applyStimulus(2, 0, '0, 0, 0, 0);
    checkOutput();
    applyStimulus(0, 2, '0, 0, 0, 0);
    checkOutput();

    // Flush keeping a stored delay slot
    applyStimulus(2, 0, '0, 0, 0, 0);
    applyStimulus(1, 0, '0, 0, 0, 0);
    checkOutput();
    expKeep = mq[1];
    applyStimulus(0, 0, '0, 1, 1, 1);
    checkOutput();
    check("keep_count", 128'(count), 128'(1));
    check("keep_entry", 128'(rdEntry[0]), 128'(expKeep));
    check("keep_hds", 128'(headInDs), 128'(1));

    // Flush with the delay slot not yet fetched
    applyStimulus(0, 0, '0, 1, 1, 2);
    checkOutput();
    applyStimulus(2, 0, '0, 0, 0, 0);
    checkOutput();
    check("ds_late_count", 128'(count), 128'(1));
    check("ds_late_entry", 128'(rdEntry[0]), 128'(lastLanes[1]));
    check("ds_late_hds", 128'(headInDs), 128'(1));

    // Delay-slot flag follows the last issued lane
    applyStimulus(2, 0, '0, 0, 0, 0);
    applyStimulus(0, 2, 2'b10, 0, 0, 0);
    checkOutput();
    check("branch_hds", 128'(headInDs), 128'(1));
    applyStimulus(0, 1, 2'b00, 0, 0, 0);
    checkOutput();
    check("nobranch_hds", 128'(headInDs), 128'(0));

    // Randomized traffic with occasional flushes
    for (int n = 0; n < 600; n++) begin
      maxR = (mq.size() < NR) ? mq.size() : NR;
      applyStimulus($urandom_range(0, NW), $urandom_range(0, maxR),
                    NR'($urandom_range(0, 3)), ($urandom_range(0, 11) == 0),
                    1'($urandom_range(0, 1)), $urandom_range(0, NR));
      checkOutput();
    end

    // Reset while waiting for a delay slot
    applyReset(0);
    applyStimulus(0, 0, '0, 1, 1, 2);
    checkOutput();
    applyReset(0);
    checkOutput();
    check("wait_reset_wr_ready", 128'(wrReady), 128'(1));

    // Reset at count=5 while a write is presented
    applyStimulus(2, 0, '0, 0, 0, 0);
    applyStimulus(2, 1, '0, 0, 0, 0);
    applyStimulus(2, 0, '0, 0, 0, 0);
    checkOutput();
    check("pre_reset_count", 128'(count), 128'(5));
    applyReset(2);
    checkOutput();
    check("mid_reset_count", 128'(count), 128'(0));
    check("mid_reset_ready", 128'(wrReady), 128'(1));
    check("mid_reset_issued", 128'(issuedCnt), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
